inputbuf_pingpong: RTL and testbench
====================================

// Module: inputbuf_pingpong
// PURPOSE
//  Parametrised successor to the single-packet input buffer: stores a packet of cfg_depth words and replays it
//  cfg_nfolds times on the output stream. Two RAM banks (ping-pong) let packet k+1 be written while packet k is
//  replayed, removing the input stall during folds 1..N-1. Depth and fold count are runtime-configurable per packet.
//  Sits between an activation producer and an MVAU-style consumer that re-reads activations once per weight fold.
// PARAMETERS
//  WIDTH      16      data word width in bits
//  DEPTH      32      max words per packet (per bank); DEPTH_LOG = $clog2(DEPTH)
//  NFOLDS     8       max replay count; NFOLDS_LOG = $clog2(NFOLDS)
//  RAM_STYLE  "auto"  synthesis ram_style attribute applied to the 2*DEPTH x WIDTH storage
// PORTS
//  aclk               in   1             clock
//  aresetn            in   1             asynchronous active-low reset
//  cfg_depth          in   DEPTH_LOG+1   words in next packet; 0 -> 1, >DEPTH -> DEPTH
//  cfg_nfolds         in   NFOLDS_LOG+1  replays of next packet; 0 -> 1, >NFOLDS -> NFOLDS
//  s_axis_tvalid      in   1             input word valid
//  s_axis_tdata       in   WIDTH         input word
//  s_axis_tready      out  1             input accept
//  m_axis_tvalid      out  1             output word valid
//  m_axis_tdata       out  WIDTH         output word
//  m_axis_tready      in   1             output accept
//  m_axis_tlast       out  1             end of fold (only with INPUTBUF_TLAST_EN)
//  status_occupancy   out  2             number of banks full or being replayed (0..2)
// BEHAVIOUR
//  - Reset (async, aresetn=0): both banks EMPTY, wr/rd bank pointers = 0, all counters 0; s_axis_tready=0,
//    m_axis_tvalid=0, m_axis_tlast=0, status_occupancy=0 immediately. RAM contents not cleared. Reset mid-packet
//    discards partial writes and in-progress replay; no output word after reset until a new full packet arrives.
//  - Per-bank state: EMPTY -> FILLING (first input handshake) -> FULL (last word written) -> EMPTY (last word of
//    last fold handshaked on output). cfg_depth/cfg_nfolds clamped and latched into the bank at its first word;
//    changes mid-packet have no effect on that packet.
//  - Write side: s_axis_tready = 1 iff current write bank is EMPTY or FILLING (registered, no comb path from
//    m_axis_tready). Handshake writes word at wr_addr, wr_addr++; at wr_addr==depth-1 bank -> FULL, wr_addr=0,
//    write pointer toggles. Both banks FULL/replaying -> s_axis_tready=0.
//  - Read side: when read bank is FULL, issue reads addr 0..depth-1, repeated nfolds times; then bank -> EMPTY and
//    read pointer toggles. Pipeline: RAM read reg + output Q reg, enables as single-packet buffer
//    (en = pending & (q_free | ~r_valid), q_free = m_axis_tready | ~q_valid): full throughput, 1 word/cycle.
//  - Latency: last input handshake at cycle t with read side idle -> m_axis_tvalid=1 at cycle t+3.
//  - Back-to-back: packet B FULL while A replays -> first word of B follows last word of A with no bubble.
//  - AXI rules: m_axis_tvalid/tdata stable while tvalid & ~tready; no word dropped or duplicated under any
//    backpressure pattern.
//  - Simultaneous: bank freed by read side and written by write side in same cycle -> read free takes effect,
//    write sees EMPTY next cycle (one-cycle tready bubble allowed only in that case).
//  - status_occupancy = count of banks in FILLING-complete states (FULL or replaying), registered.
//  - Word order out: per fold, addr 0..depth-1 in input order; depth=1 replays the single word nfolds times.
// CONFIGURATION
//  INPUTBUF_TLAST_EN defined: m_axis_tlast=1 with the word at addr depth-1 of every fold, travels with tdata in the
//  pipeline, reset 0. Undefined: m_axis_tlast port absent, no tlast pipeline registers.
// TESTING
//  1. depth=4,nfolds=3, send A0..A3, tready=1 -> out A0..A3 x3 (12 words), first tvalid at t+3, occupancy 1->0.
//  2. Two packets back-to-back (depth=4,nfolds=2) -> input never stalls on packet 2; 16 output words, no bubble.
//  3. Random tready (50%) with depth=DEPTH,nfolds=NFOLDS -> scoreboard exact order, tdata stable under stall.
//  4. cfg_depth=0,cfg_nfolds=0 then cfg changed mid-packet -> 1 word replayed once; mid-packet change ignored.
//  5. Three packets with tready=0 -> s_axis_tready drops after 8 words (depth=4), occupancy=2; release -> all data.
//  6. aresetn low mid-replay -> tvalid=0 same cycle; new packet after release replays correctly, tlast on addr 3.

Source files
------------

// File: rtl/inputbuf_pingpong.sv
// inputbuf_pingpong
//   Two-bank (ping-pong) packet buffer. A packet of cfg_depth words is stored
//   in one bank and replayed cfg_nfolds times on the output stream while the
//   next packet is written into the other bank. Depth and fold count are
//   clamped to 1..DEPTH / 1..NFOLDS and latched per bank at the packet's
//   first word.
//
//   Optional feature macro: INPUTBUF_TLAST_EN
//     defined   -> m_axis_tlast marks the last word of every fold
//     undefined -> no m_axis_tlast port, no tlast pipeline registers
//
//   Ports
//     aclk, aresetn     clock, asynchronous active-low reset
//     cfg_depth         words in next packet (0 -> 1, >DEPTH -> DEPTH)
//     cfg_nfolds        replays of next packet (0 -> 1, >NFOLDS -> NFOLDS)
//     s_axis_*          input word stream (tvalid/tdata/tready)
//     m_axis_*          output word stream (tvalid/tdata/tready[/tlast])
//     status_occupancy  banks that are full or being replayed (0..2)
module inputbuf_pingpong #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 32,
  parameter int NFOLDS     = 8,
  parameter     RAM_STYLE  = "auto",
  localparam int DEPTH_LOG  = $clog2(DEPTH),
  localparam int NFOLDS_LOG = $clog2(NFOLDS)
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [DEPTH_LOG:0]  cfg_depth,
  input  logic [NFOLDS_LOG:0] cfg_nfolds,
  input  logic                s_axis_tvalid,
  input  logic [WIDTH-1:0]    s_axis_tdata,
  output logic                s_axis_tready,
  output logic                m_axis_tvalid,
  output logic [WIDTH-1:0]    m_axis_tdata,
  input  logic                m_axis_tready,
`ifdef INPUTBUF_TLAST_EN
  output logic                m_axis_tlast,
`endif
  output logic [1:0]          status_occupancy
);

  localparam int DW = DEPTH_LOG + 1;
  localparam int FW = NFOLDS_LOG + 1;
  localparam int AW = $clog2(2 * DEPTH);

  // DRAIN: every word of the bank has been read out of the RAM, but the last
  // one has not yet been accepted downstream. The bank must not be re-read
  // or rewritten while in this state.
  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAIN
  } bank_state_e;

  bank_state_e           bankState_q [2];
  bank_state_e           bankState_d [2];
  logic [DW-1:0]         bankDepth_q [2];
  logic [FW-1:0]         bankFolds_q [2];

  logic                  wrPtr_q, wrPtr_d;
  logic [DEPTH_LOG-1:0]  wrAddr_q, wrAddr_d;
  logic                  sTready_q, sTready_d;
  logic [1:0]            occ_q, occ_d;

  logic                  rdPtr_q, rdPtr_d;
  logic [DEPTH_LOG-1:0]  rdAddr_q, rdAddr_d;
  logic [NFOLDS_LOG-1:0] rdFold_q, rdFold_d;
  logic                  freePtr_q, freePtr_d;

  logic                  rValid_q, rEnd_q;
  logic [WIDTH-1:0]      rData_q;
  logic                  qValid_q, qEnd_q;
  logic [WIDTH-1:0]      qData_q;
`ifdef INPUTBUF_TLAST_EN
  logic                  rLast_q, qLast_q;
`endif

  logic                  wrFire, wrFirst, wrLast;
  logic [DW-1:0]         wrDepth;
  logic                  pending, qFree, rdEn, qEn, outFire;
  logic                  rdLastAddr, rdLastFold, rdLastWord;
  logic [AW-1:0]         wrIdx, rdIdx;

  function automatic logic [DW-1:0] clampDepth(input logic [DW-1:0] req);
    if (req == '0)              return DW'(1);
    else if (req > DW'(DEPTH))  return DW'(DEPTH);
    else                        return req;
  endfunction

  function automatic logic [FW-1:0] clampFolds(input logic [FW-1:0] req);
    if (req == '0)              return FW'(1);
    else if (req > FW'(NFOLDS)) return FW'(NFOLDS);
    else                        return req;
  endfunction

  // Decode of the current bank states into write/read side events. The
  // first word of a packet uses the live (clamped) config, later words the
  // value latched into the bank.
  always_comb begin
    wrFire     = s_axis_tvalid & sTready_q;
    wrFirst    = (bankState_q[wrPtr_q] == BANK_EMPTY);
    wrDepth    = wrFirst ? clampDepth(cfg_depth) : bankDepth_q[wrPtr_q];
    wrLast     = ({1'b0, wrAddr_q} == wrDepth - DW'(1));

    pending    = (bankState_q[rdPtr_q] == BANK_FULL);
    qFree      = m_axis_tready | ~qValid_q;
    rdEn       = pending & (qFree | ~rValid_q);
    qEn        = rValid_q & qFree;
    outFire    = qValid_q & m_axis_tready;
    rdLastAddr = ({1'b0, rdAddr_q} == bankDepth_q[rdPtr_q] - DW'(1));
    rdLastFold = ({1'b0, rdFold_q} == bankFolds_q[rdPtr_q] - FW'(1));
    rdLastWord = rdLastAddr & rdLastFold;

    wrIdx      = AW'(wrAddr_q) + (wrPtr_q ? AW'(DEPTH) : AW'(0));
    rdIdx      = AW'(rdAddr_q) + (rdPtr_q ? AW'(DEPTH) : AW'(0));
  end

  // Bank next-state. Writer, reader and drain each touch a bank in a
  // different state, so the three updates never collide on one bank.
  always_comb begin
    for (int b = 0; b < 2; b++) bankState_d[b] = bankState_q[b];
    if (wrFire)             bankState_d[wrPtr_q]   = wrLast ? BANK_FULL : BANK_FILLING;
    if (rdEn && rdLastWord) bankState_d[rdPtr_q]   = BANK_DRAIN;
    if (outFire && qEnd_q)  bankState_d[freePtr_q] = BANK_EMPTY;
  end

  // Pointer/counter next-state and the values behind the registered outputs.
  always_comb begin
    wrPtr_d   = wrPtr_q;
    wrAddr_d  = wrAddr_q;
    rdPtr_d   = rdPtr_q;
    rdAddr_d  = rdAddr_q;
    rdFold_d  = rdFold_q;
    freePtr_d = (outFire && qEnd_q) ? ~freePtr_q : freePtr_q;
    if (wrFire) begin
      if (wrLast) begin
        wrAddr_d = '0;
        wrPtr_d  = ~wrPtr_q;
      end else begin
        wrAddr_d = wrAddr_q + DEPTH_LOG'(1);
      end
    end
    if (rdEn) begin
      if (rdLastAddr) begin
        rdAddr_d = '0;
        if (rdLastFold) begin
          rdFold_d = '0;
          rdPtr_d  = ~rdPtr_q;
        end else begin
          rdFold_d = rdFold_q + NFOLDS_LOG'(1);
        end
      end else begin
        rdAddr_d = rdAddr_q + DEPTH_LOG'(1);
      end
    end
    sTready_d = (bankState_d[wrPtr_d] == BANK_EMPTY) ||
                (bankState_d[wrPtr_d] == BANK_FILLING);
    occ_d = '0;
    for (int b = 0; b < 2; b++) begin
      if (bankState_d[b] == BANK_FULL || bankState_d[b] == BANK_DRAIN) occ_d = occ_d + 2'd1;
    end
  end

  // State register for banks, pointers, per-bank config and output pipeline.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int b = 0; b < 2; b++) begin
        bankState_q[b] <= BANK_EMPTY;
        bankDepth_q[b] <= '0;
        bankFolds_q[b] <= '0;
      end
      wrPtr_q   <= 1'b0;
      wrAddr_q  <= '0;
      sTready_q <= 1'b0;
      occ_q     <= '0;
      rdPtr_q   <= 1'b0;
      rdAddr_q  <= '0;
      rdFold_q  <= '0;
      freePtr_q <= 1'b0;
      rValid_q  <= 1'b0;
      rEnd_q    <= 1'b0;
      qValid_q  <= 1'b0;
      qEnd_q    <= 1'b0;
      qData_q   <= '0;
    end else begin
      bankState_q <= bankState_d;
      if (wrFire && wrFirst) begin
        bankDepth_q[wrPtr_q] <= clampDepth(cfg_depth);
        bankFolds_q[wrPtr_q] <= clampFolds(cfg_nfolds);
      end
      wrPtr_q   <= wrPtr_d;
      wrAddr_q  <= wrAddr_d;
      sTready_q <= sTready_d;
      occ_q     <= occ_d;
      rdPtr_q   <= rdPtr_d;
      rdAddr_q  <= rdAddr_d;
      rdFold_q  <= rdFold_d;
      freePtr_q <= freePtr_d;
      rValid_q  <= rdEn | (rValid_q & ~qEn);
      qValid_q  <= qEn | (qValid_q & ~m_axis_tready);
      if (rdEn) rEnd_q <= rdLastWord;
      if (qEn) begin
        qEnd_q  <= rEnd_q;
        qData_q <= rData_q;
      end
    end
  end

`ifdef INPUTBUF_TLAST_EN
  // End-of-fold flag travels alongside the data through both stages.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rLast_q <= 1'b0;
      qLast_q <= 1'b0;
    end else begin
      if (rdEn) rLast_q <= rdLastAddr;
      if (qEn)  qLast_q <= rLast_q;
    end
  end
  assign m_axis_tlast = qLast_q;
`endif

  // Storage for both banks; bank 1 lives at offset DEPTH. The synchronous
  // read register is kept reset-free so the array maps onto block RAM.
  if (RAM_STYLE == "block") begin : gRamBlock
    (* ram_style = "block" *) logic [WIDTH-1:0] mem [2*DEPTH];
    always_ff @(posedge aclk) begin
      if (wrFire) mem[wrIdx] <= s_axis_tdata;
      if (rdEn)   rData_q    <= mem[rdIdx];
    end
  end else if (RAM_STYLE == "distributed") begin : gRamDist
    (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [2*DEPTH];
    always_ff @(posedge aclk) begin
      if (wrFire) mem[wrIdx] <= s_axis_tdata;
      if (rdEn)   rData_q    <= mem[rdIdx];
    end
  end else begin : gRamAuto
    (* ram_style = "auto" *) logic [WIDTH-1:0] mem [2*DEPTH];
    always_ff @(posedge aclk) begin
      if (wrFire) mem[wrIdx] <= s_axis_tdata;
      if (rdEn)   rData_q    <= mem[rdIdx];
    end
  end

  assign s_axis_tready    = sTready_q;
  assign m_axis_tvalid    = qValid_q;
  assign m_axis_tdata     = qData_q;
  assign status_occupancy = occ_q;

endmodule

// File: tb/tb_inputbuf_pingpong.sv
// tb_inputbuf_pingpong
//   Directed sequence with random data and random output backpressure. The
//   expected output stream is built per packet from the clamped depth/folds
//   (every fold repeats the packet words in input order) and compared word
//   by word by a monitor that also checks tdata stability under stall.
module tb_inputbuf_pingpong;

  localparam int WIDTH = 16;
  localparam int DEPTH = 32;
  localparam int NFOLDS = 8;
  localparam int DL = $clog2(DEPTH);
  localparam int NL = $clog2(NFOLDS);

  logic             aclk;
  logic             aresetn;
  logic [DL:0]      cfgDepth;
  logic [NL:0]      cfgFolds;
  logic             sTvalid;
  logic [WIDTH-1:0] sTdata;
  logic             sTready;
  logic             mTvalid;
  logic [WIDTH-1:0] mTdata;
  logic             mTready;
  logic [1:0]       occ;
`ifdef INPUTBUF_TLAST_EN
  logic             mTlast;
  logic             expLast[$];
  logic             expLastBit;
`endif

  int tests;
  int fails;
  int stalls;
  int guard;
  int gapCycles;
  bit bpRandom;

  logic [WIDTH-1:0] expData[$];
  logic [WIDTH-1:0] expWord;
  logic [WIDTH-1:0] prevData;
  bit               prevStall;
  bit               haveExp;
  bit               inBurst;

  inputbuf_pingpong #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .NFOLDS(NFOLDS),
    .RAM_STYLE("auto")
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .cfg_depth(cfgDepth),
    .cfg_nfolds(cfgFolds),
    .s_axis_tvalid(sTvalid),
    .s_axis_tdata(sTdata),
    .s_axis_tready(sTready),
    .m_axis_tvalid(mTvalid),
    .m_axis_tdata(mTdata),
    .m_axis_tready(mTready),
`ifdef INPUTBUF_TLAST_EN
    .m_axis_tlast(mTlast),
`endif
    .status_occupancy(occ)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic int clampCfg(input int req, input int maxVal);
    if (req < 1) return 1;
    if (req > maxVal) return maxVal;
    return req;
  endfunction

  // Output monitor: every accepted word must be the next expected one, and a
  // stalled word must stay put until accepted.
  always @(negedge aclk) begin
    if (aresetn !== 1'b1) begin
      prevStall = 1'b0;
      inBurst   = 1'b0;
    end else begin
      if (prevStall) begin
        tests++;
        assert (mTvalid === 1'b1 && mTdata === prevData) else begin
          fails++;
          $error("[TB] FAIL stallHold observed valid=%0b data=%h expected valid=1 data=%h", mTvalid, mTdata, prevData);
        end
      end
      if (inBurst && mTvalid !== 1'b1 && mTready === 1'b1) gapCycles++;
      if (mTvalid === 1'b1 && mTready === 1'b1) begin
        tests++;
        haveExp = (expData.size() != 0);
        expWord = '0;
        if (haveExp) expWord = expData.pop_front();
        assert (haveExp && mTdata === expWord) else begin
          fails++;
          $error("[TB] FAIL outWord observed=%h expected=%h expectedPresent=%0b", mTdata, expWord, haveExp);
        end
`ifdef INPUTBUF_TLAST_EN
        expLastBit = 1'b0;
        if (expLast.size() != 0) expLastBit = expLast.pop_front();
        tests++;
        assert (mTlast === expLastBit) else begin
          fails++;
          $error("[TB] FAIL outLast observed=%0b expected=%0b", mTlast, expLastBit);
        end
`endif
        inBurst = (expData.size() != 0);
      end
      prevStall = (mTvalid === 1'b1) && (mTready !== 1'b1);
      prevData  = mTdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge and redraw backpressure.
  task automatic stepCycle();
    @(posedge aclk);
    #1;
    if (bpRandom) mTready = 1'($urandom_range(0, 1));
  endtask

  task automatic sendWord(input logic [WIDTH-1:0] d, output int waited);
    int g;
    g = 0;
    waited = 0;
    sTvalid = 1'b1;
    sTdata  = d;
    @(negedge aclk);
    while (sTready !== 1'b1 && g < 1000) begin
      stepCycle();
      @(negedge aclk);
      g++;
      waited++;
    end
    check("sendAccept", 32'(sTready), 32'd1);
    stepCycle();
  endtask

  // Sends one packet; midD >= 0 changes the config after the first word.
  task automatic sendPacket(input int dCfg, input int nCfg, input int midD, input int midN, output int stallTotal);
    int d;
    int n;
    int w;
    logic [WIDTH-1:0] words[$];
    d = clampCfg(dCfg, DEPTH);
    n = clampCfg(nCfg, NFOLDS);
    for (int i = 0; i < d; i++) words.push_back(WIDTH'($urandom));
    for (int f = 0; f < n; f++) begin
      for (int a = 0; a < d; a++) begin
        expData.push_back(words[a]);
`ifdef INPUTBUF_TLAST_EN
        expLast.push_back(a == d - 1);
`endif
      end
    end
    stepCycle();
    cfgDepth = (DL+1)'(dCfg);
    cfgFolds = (NL+1)'(nCfg);
    stallTotal = 0;
    for (int i = 0; i < d; i++) begin
      sendWord(words[i], w);
      stallTotal += w;
      if (i == 0 && midD >= 0) begin
        cfgDepth = (DL+1)'(midD);
        cfgFolds = (NL+1)'(midN);
      end
    end
    sTvalid = 1'b0;
  endtask

  task automatic waitDrain(input int limit);
    int g;
    g = 0;
    while (expData.size() != 0 && g < limit) begin
      stepCycle();
      @(negedge aclk);
      g++;
    end
    check("drainEmpty", 32'(expData.size()), 32'd0);
    stepCycle();
    stepCycle();
  endtask

  initial begin
    tests = 0; fails = 0; gapCycles = 0; bpRandom = 1'b0;
    aresetn = 1'b1; sTvalid = 1'b0; sTdata = '0; mTready = 1'b0;
    cfgDepth = '0; cfgFolds = '0;
    #2 aresetn = 1'b0;
    #1;
    check("rstSTready", 32'(sTready), 32'd0);
    check("rstMTvalid", 32'(mTvalid), 32'd0);
    check("rstOcc", 32'(occ), 32'd0);
`ifdef INPUTBUF_TLAST_EN
    check("rstTlast", 32'(mTlast), 32'd0);
`endif
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    repeat (2) stepCycle();

    // 1: depth 4, 3 folds, latency and occupancy
    mTready = 1'b1;
    sendPacket(4, 3, -1, -1, stalls);
    @(negedge aclk);
    check("latT1Valid", 32'(mTvalid), 32'd0);
    check("latT1Occ", 32'(occ), 32'd1);
    @(negedge aclk);
    check("latT2Valid", 32'(mTvalid), 32'd0);
    @(negedge aclk);
    check("latT3Valid", 32'(mTvalid), 32'd1);
    waitDrain(200);
    check("drainOcc", 32'(occ), 32'd0);

    // 2: back-to-back packets, no input stall, no output bubble
    gapCycles = 0;
    sendPacket(4, 2, -1, -1, stalls);
    check("b2bStallA", 32'(stalls), 32'd0);
    sendPacket(4, 2, -1, -1, stalls);
    check("b2bStallB", 32'(stalls), 32'd0);
    waitDrain(200);
    check("b2bGaps", 32'(gapCycles), 32'd0);

    // 3: full-size packets (one with over-range config) under random backpressure
    bpRandom = 1'b1;
    sendPacket(63, 15, -1, -1, stalls);
    sendPacket(DEPTH, NFOLDS, -1, -1, stalls);
    waitDrain(4000);
    bpRandom = 1'b0;
    mTready = 1'b1;

    // 4: zero config, mid-packet config change, single-word multi-fold
    sendPacket(0, 0, -1, -1, stalls);
    waitDrain(100);
    sendPacket(3, 2, 1, 5, stalls);
    waitDrain(100);
    sendPacket(1, 4, -1, -1, stalls);
    waitDrain(100);

    // 5: both banks full with output blocked
    mTready = 1'b0;
    sendPacket(4, 2, -1, -1, stalls);
    sendPacket(4, 2, -1, -1, stalls);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("fullSTready", 32'(sTready), 32'd0);
      check("fullOcc", 32'(occ), 32'd2);
      stepCycle();
    end
    mTready = 1'b1;
    sendPacket(4, 2, -1, -1, stalls);
    waitDrain(300);

    // 6: reset during replay, then a fresh packet
    sendPacket(4, 4, -1, -1, stalls);
    guard = 0;
    do begin
      @(negedge aclk);
      guard++;
    end while (mTvalid !== 1'b1 && guard < 50);
    check("rstWaitValid", 32'(mTvalid), 32'd1);
    stepCycle();
    stepCycle();
    aresetn = 1'b0;
    #1;
    check("midRstValid", 32'(mTvalid), 32'd0);
    check("midRstSTready", 32'(sTready), 32'd0);
    check("midRstOcc", 32'(occ), 32'd0);
`ifdef INPUTBUF_TLAST_EN
    check("midRstTlast", 32'(mTlast), 32'd0);
    expLast.delete();
`endif
    expData.delete();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      @(negedge aclk);
      check("postRstIdle", 32'(mTvalid), 32'd0);
    end
    sendPacket(4, 2, -1, -1, stalls);
    waitDrain(200);
    repeat (10) stepCycle();
    check("finalQueue", 32'(expData.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
